instr_mem_ctrl: RTL and testbench

//  Parametrised, loadable instruction memory for the fetch stage.

---
 rtl/instr_mem_ctrl.sv | 144 ++++++++++++++
 tb/tb_instr_mem_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_ctrl.sv
// Loadable instruction memory for the fetch stage: registered fetch port with valid/stall
// handshake and a sequential program-load port. Optional parity: define INSTR_PARITY_EN.
module instr_mem_ctrl #(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 16,
    parameter int                DEPTH     = 64,
    parameter logic [DATA_W-1:0] FILL_WORD = 16'hFFFF,
    parameter logic [DATA_W-1:0] RST_WORD  = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] PC,
    input  logic              fetch_req,
    output logic              fetch_rdy,
    output logic [DATA_W-1:0] INSTR,
    output logic              instr_valid,
    input  logic              instr_stall,
    output logic              oob,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_busy,
`ifdef INSTR_PARITY_EN
    output logic              par_err,
`endif
    output logic [ADDR_W:0]   ld_count
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
`ifdef INSTR_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    typedef enum logic {RUN, LOAD} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_en;
    logic [MEM_W-1:0]  mem [DEPTH];
    logic [MEM_W-1:0]  wr_word, rd_word;
    logic              in_range, accept, hold;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              valid_q, valid_d, oob_q, oob_d;

    // The load counter doubles as the write pointer; it stops at DEPTH so excess words drop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        case (state_q)
            RUN: begin
                if (ld_start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (ld_start) begin
                    cnt_d = '0;
                end else if (ld_valid) begin
                    if (cnt_q < DEPTH_C) begin
                        wr_en = 1'b1;
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (ld_last) state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef INSTR_PARITY_EN
    assign wr_word = {^ld_data, ld_data};
`else
    assign wr_word = ld_data;
`endif

    // Contents are deliberately not reset so a program survives rst_n.
    always_ff @(posedge clk) begin
        if (wr_en) mem[cnt_q[IDX_W-1:0]] <= wr_word;
    end

    assign rd_word   = mem[PC[IDX_W-1:0]];
    assign in_range  = {1'b0, PC} < DEPTH_C;
    assign hold      = valid_q & instr_stall;
    assign fetch_rdy = (state_q == RUN) & ~hold;
    assign accept    = fetch_req & fetch_rdy;

    always_comb begin
        instr_d = instr_q;
        oob_d   = oob_q;
        valid_d = 1'b0;
        if (accept) begin
            instr_d = in_range ? rd_word[DATA_W-1:0] : FILL_WORD;
            oob_d   = ~in_range;
            valid_d = 1'b1;
        end else if (hold) begin
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= RST_WORD;
            valid_q <= 1'b0;
            oob_q   <= 1'b0;
        end else begin
            instr_q <= instr_d;
            valid_q <= valid_d;
            oob_q   <= oob_d;
        end
    end

`ifdef INSTR_PARITY_EN
    logic par_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      par_q <= 1'b0;
        else if (accept) par_q <= in_range & (^rd_word);
    end
    assign par_err = par_q;
`endif

    assign INSTR       = instr_q;
    assign instr_valid = valid_q;
    assign oob         = oob_q;
    assign ld_busy     = (state_q == LOAD);
    assign ld_count    = cnt_q;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Bench for instr_mem_ctrl: behavioural model plus per-cycle compare, directed scenarios
// with literal expectations, then randomized fetch/stall/load traffic.
module tb_instr_mem_ctrl;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int DEPTH = 64;
    localparam logic [DW-1:0] FILL = 16'hFFFF;
    localparam logic [DW-1:0] RSTW = 16'h0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] PC = '0;
    logic          fetch_req = 1'b0, instr_stall = 1'b0;
    logic          ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
    logic [DW-1:0] ld_data = '0;
    logic          fetch_rdy, instr_valid, oob, ld_busy;
    logic [DW-1:0] INSTR;
    logic [AW:0]   ld_count;
`ifdef INSTR_PARITY_EN
    logic          par_err;
`endif

    int n_chk = 0;
    int n_fail = 0;

    instr_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .FILL_WORD(FILL), .RST_WORD(RSTW)) dut (
        .clk(clk), .rst_n(rst_n), .PC(PC), .fetch_req(fetch_req), .fetch_rdy(fetch_rdy),
        .INSTR(INSTR), .instr_valid(instr_valid), .instr_stall(instr_stall), .oob(oob),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_busy(ld_busy),
`ifdef INSTR_PARITY_EN
        .par_err(par_err),
`endif
        .ld_count(ld_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: program image, load progress and the fetch result register.
    logic [DW-1:0] mm [DEPTH];
    bit            corrupt [DEPTH];
    bit            loading;
    int            cnt;
    logic [DW-1:0] e_instr;
    bit            e_valid, e_oob, e_par, m_hold;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loading = 0; cnt = 0; e_instr = RSTW; e_valid = 0; e_oob = 0; e_par = 0;
        end else begin
            m_hold = e_valid && instr_stall;
            if (fetch_req && !loading && !m_hold) begin
                e_valid = 1;
                if (int'(PC) < DEPTH) begin
                    e_instr = mm[int'(PC)]; e_oob = 0; e_par = corrupt[int'(PC)];
                end else begin
                    e_instr = FILL; e_oob = 1; e_par = 0;
                end
            end else if (!m_hold) begin
                e_valid = 0;
            end
            if (ld_start) begin
                loading = 1; cnt = 0;
            end else if (loading && ld_valid) begin
                if (cnt < DEPTH) begin
                    mm[cnt] = ld_data; corrupt[cnt] = 0; cnt++;
                end
                if (ld_last) loading = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("fetch_rdy", 32'(fetch_rdy), 32'(!loading && !(e_valid && instr_stall)));
        chk("INSTR", 32'(INSTR), 32'(e_instr));
        chk("instr_valid", 32'(instr_valid), 32'(e_valid));
        chk("oob", 32'(oob), 32'(e_oob));
        chk("ld_busy", 32'(ld_busy), 32'(loading));
        chk("ld_count", 32'(ld_count), 32'(cnt));
`ifdef INSTR_PARITY_EN
        chk("par_err", 32'(par_err), 32'(e_par));
`endif
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic ld_word(input logic [DW-1:0] d, input logic last);
        ld_valid = 1'b1; ld_data = d; ld_last = last;
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    task automatic ld_begin();
        ld_start = 1'b1; tick(); ld_start = 1'b0;
    endtask

    task automatic fetch(input int pc);
        fetch_req = 1'b1; PC = AW'(pc); tick();
    endtask

    initial begin
        repeat (3) tick();
        chk("rst INSTR", 32'(INSTR), 32'h0000);
        chk("rst valid", 32'(instr_valid), 0);
        chk("rst fetch_rdy", 32'(fetch_rdy), 1);
        chk("rst ld_busy", 32'(ld_busy), 0);
        chk("rst ld_count", 32'(ld_count), 0);
        rst_n = 1'b1;
        tick();

        // Fill the whole array so every later fetch has a known value.
        ld_begin();
        for (int i = 0; i < DEPTH; i++) ld_word(DW'($urandom), i == DEPTH - 1);

        ld_begin();
        ld_word(16'h0000, 0); ld_word(16'h2456, 0); ld_word(16'hA061, 1);
        chk("load3 count", 32'(ld_count), 3);
        chk("load3 busy", 32'(ld_busy), 0);
        fetch(1); chk("pc1", 32'(INSTR), 32'h2456);
        fetch(2); chk("pc2", 32'(INSTR), 32'hA061);
        chk("pc2 valid", 32'(instr_valid), 1);
        fetch_req = 1'b0; tick();
        chk("idle valid", 32'(instr_valid), 0);
        chk("idle hold", 32'(INSTR), 32'hA061);

        fetch(DEPTH); chk("oob word", 32'(INSTR), 32'hFFFF); chk("oob flag", 32'(oob), 1);
        fetch(0); chk("pc0 oob", 32'(oob), 0); chk("pc0 word", 32'(INSTR), 32'h0000);
        fetch_req = 1'b0; tick();

        instr_stall = 1'b1;
        fetch(1);
        for (int i = 0; i < 3; i++) begin
            chk("stall rdy", 32'(fetch_rdy), 0);
            chk("stall word", 32'(INSTR), 32'h2456);
            chk("stall valid", 32'(instr_valid), 1);
            tick();
        end
        instr_stall = 1'b0; PC = 16'd2; #1;
        chk("release rdy", 32'(fetch_rdy), 1);
        tick(); chk("after stall", 32'(INSTR), 32'hA061);
        fetch_req = 1'b0; tick();

        ld_begin();
        for (int i = 0; i < DEPTH + 2; i++) ld_word(16'h1000 + DW'(i), i == DEPTH + 1);
        chk("sat count", 32'(ld_count), DEPTH);
        fetch(0); chk("sat pc0", 32'(INSTR), 32'h1000);
        fetch(DEPTH - 1); chk("sat last", 32'(INSTR), 32'h1000 + DEPTH - 1);
        fetch_req = 1'b0; tick();

        ld_begin();
        ld_word(16'hBEEF, 0); ld_word(16'hCAFE, 0);
        chk("midload busy", 32'(ld_busy), 1);
        rst_n = 1'b0; #1;
        chk("rstload busy", 32'(ld_busy), 0);
        chk("rstload count", 32'(ld_count), 0);
        tick(); rst_n = 1'b1; tick();
        fetch(0); chk("kept pc0", 32'(INSTR), 32'hBEEF);
        fetch(1); chk("kept pc1", 32'(INSTR), 32'hCAFE);
        fetch(2); chk("kept pc2", 32'(INSTR), 32'h1002);
        fetch_req = 1'b0; tick();

`ifdef INSTR_PARITY_EN
        dut.mem[3][0] = ~dut.mem[3][0];
        mm[3][0] = ~mm[3][0];
        corrupt[3] = 1;
        fetch(3); chk("par bad", 32'(par_err), 1);
        fetch(2); chk("par good", 32'(par_err), 0);
        fetch_req = 1'b0; tick();
`endif

        for (int c = 0; c < 3000; c++) begin
            fetch_req   = ($urandom % 4) != 0;
            PC          = AW'($urandom_range(0, DEPTH + 3));
            instr_stall = ($urandom % 4) == 0;
            ld_start    = ($urandom % 64) == 0;
            ld_valid    = ($urandom % 2) == 1;
            ld_data     = DW'($urandom);
            ld_last     = ($urandom % 16) == 0;
            tick();
        end
        fetch_req = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; instr_stall = 1'b0;
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
